// File: rtl/hmac_sha1_if.sv
// Bundles the OTP front-end handshake and the SHA-1 core connection of hmac_sha1.
// slave is the sequencer's view; master is the view of the surrounding logic (front end plus core).
interface hmac_sha1_if;
    logic         start;
    logic [511:0] key;
    logic [63:0]  counter;
    logic         busy;
    logic         done;
    logic [159:0] mac;
    logic         sha_reset;
    logic         sha_feed;
    logic [511:0] sha_message;
    logic [159:0] sha_hash;
    logic         sha_done;

    modport slave (
        input  start, key, counter, sha_hash, sha_done,
        output busy, done, mac, sha_reset, sha_feed, sha_message
    );

    modport master (
        output start, key, counter, sha_hash, sha_done,
        input  busy, done, mac, sha_reset, sha_feed, sha_message
    );
endinterface

// File: rtl/hmac_sha1.sv
// HMAC-SHA1 sequencer for HOTP/TOTP: steps one single-block SHA-1 core through
// the inner and outer two-block passes over an 8-byte moving factor.
module hmac_sha1 (
    input  logic        clk,
    input  logic        reset,
    hmac_sha1_if.slave  bus
);

    typedef enum logic [3:0] {
        IDLE, INIT_IN, FEED_I1, WAIT_I1, FEED_I2, WAIT_I2,
        INIT_OUT, FEED_O1, WAIT_O1, FEED_O2, WAIT_O2
    } state_t;

    state_t        state_q;
    logic [511:0]  key_q;
    logic [63:0]   ctr_q;
    logic [159:0]  inner_q;
    logic [159:0]  mac_q;
    logic          done_q;
    logic          feed_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            key_q   <= '0;
            ctr_q   <= '0;
            inner_q <= '0;
            mac_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        key_q   <= bus.key;
                        ctr_q   <= bus.counter;
                        state_q <= INIT_IN;
                    end
                end
                INIT_IN:  state_q <= FEED_I1;
                FEED_I1:  if (bus.sha_done) state_q <= WAIT_I1;
                WAIT_I1:  if (bus.sha_done) state_q <= FEED_I2;
                FEED_I2:  if (bus.sha_done) state_q <= WAIT_I2;
                WAIT_I2: begin
                    if (bus.sha_done) begin
                        inner_q <= bus.sha_hash;
                        state_q <= INIT_OUT;
                    end
                end
                INIT_OUT: state_q <= FEED_O1;
                FEED_O1:  if (bus.sha_done) state_q <= WAIT_O1;
                WAIT_O1:  if (bus.sha_done) state_q <= FEED_O2;
                FEED_O2:  if (bus.sha_done) state_q <= WAIT_O2;
                WAIT_O2: begin
                    if (bus.sha_done) begin
                        mac_q   <= bus.sha_hash;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default:  state_q <= IDLE;
            endcase
        end
    end

    // A feed is only issued when the core reports ready, so each pulse is one cycle.
    assign feed_state = (state_q == FEED_I1) || (state_q == FEED_I2) ||
                        (state_q == FEED_O1) || (state_q == FEED_O2);

    assign bus.sha_feed  = feed_state && bus.sha_done;
    assign bus.sha_reset = reset || (state_q == INIT_IN) || (state_q == INIT_OUT);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.mac       = mac_q;

    always_comb begin
        bus.sha_message = '0;
        case (state_q)
            FEED_I1: bus.sha_message = key_q ^ {64{8'h36}};
            FEED_I2: bus.sha_message = {ctr_q, 8'h80, 376'b0, 64'd576};
            FEED_O1: bus.sha_message = key_q ^ {64{8'h5c}};
            FEED_O2: bus.sha_message = {inner_q, 8'h80, 280'b0, 64'd672};
            default: bus.sha_message = '0;
        endcase
    end

endmodule

// File: tb/tb_hmac_sha1.sv
// Testbench for hmac_sha1: behavioural single-block SHA-1 core plus directed
// HMAC runs against RFC 4226 vectors and a software model for the all-zero key.
module tb_hmac_sha1;

    localparam logic [159:0] SHA_IV  = 160'h67452301efcdab8998badcfe10325476c3d2e1f0;
    localparam logic [511:0] RFC_KEY = {160'h3132333435363738393031323334353637383930, 352'b0};
    localparam logic [159:0] V0 = 160'hcc93cf18508d94934c64b65d8ba7667fb7cde4b0;
    localparam logic [159:0] V1 = 160'h75a48a19d4cbe100644e8ac1397eea747a2d33ab;
    localparam logic [159:0] V2 = 160'h0bacb7fa082fef30782211938bc1c5e70416ff44;
    localparam logic [159:0] V3 = 160'h66c28227d03a2d5529262ff016a1e6ef76557ece;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    hmac_sha1_if bus ();

    hmac_sha1 dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [159:0] sha1_compress(input logic [159:0] h, input logic [511:0] blk);
        logic [31:0] w [0:79];
        logic [31:0] a, b, c, d, e, f, k, t, x;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 80; i++) begin
            x = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
            w[i] = {x[30:0], x[31]};
        end
        a = h[159:128]; b = h[127:96]; c = h[95:64]; d = h[63:32]; e = h[31:0];
        for (int i = 0; i < 80; i++) begin
            if (i < 20) begin
                f = (b & c) | (~b & d); k = 32'h5a827999;
            end else if (i < 40) begin
                f = b ^ c ^ d;          k = 32'h6ed9eba1;
            end else if (i < 60) begin
                f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc;
            end else begin
                f = b ^ c ^ d;          k = 32'hca62c1d6;
            end
            t = {a[26:0], a[31:27]} + f + e + k + w[i];
            e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
        end
        return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
    endfunction

    // Core model: ready (done=1) after reset, drops done on feed, done again 82 edges later.
    logic [159:0] core_h    = '0;
    logic [511:0] core_blk  = '0;
    logic         core_done = 1'b0;
    int           core_cnt  = 0;

    assign bus.sha_hash = core_h;
    assign bus.sha_done = core_done;

    always @(posedge clk) begin
        if (bus.sha_reset) begin
            core_h    <= SHA_IV;
            core_done <= 1'b1;
            core_cnt  <= 0;
        end else if (bus.sha_feed && core_done) begin
            core_blk  <= bus.sha_message;
            core_done <= 1'b0;
            core_cnt  <= 82;
        end else if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) begin
                core_h    <= sha1_compress(core_h, core_blk);
                core_done <= 1'b1;
            end
        end
    end

    int            n_feed = 0;
    int            n_sreset = 0;
    int            n_done = 0;
    int            n_feed_bad = 0;
    logic [511:0]  msg_q [$];

    always @(posedge clk) begin
        if (!rst) begin
            if (bus.sha_feed) begin
                n_feed++;
                msg_q.push_back(bus.sha_message);
                if (!bus.sha_done) n_feed_bad++;
            end
            if (bus.sha_reset) n_sreset++;
            if (bus.done) n_done++;
        end
    end

    task automatic clear_counts();
        n_feed = 0; n_sreset = 0; n_done = 0; n_feed_bad = 0;
        msg_q.delete();
    endtask

    // Issues one request in the current cycle and returns in the cycle where done is high.
    task automatic run_req(input logic [511:0] k, input logic [63:0] c,
                           output logic [159:0] m, output int lat, output int nbusy, output int nchg);
        logic [159:0] m0;
        m0 = bus.mac;
        bus.key = k; bus.counter = c; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1; nbusy = 0; nchg = 0;
        while (!bus.done && lat < 1000) begin
            if (bus.busy) nbusy++;
            if (bus.mac !== m0) nchg++;
            @(posedge clk); #1;
            lat++;
        end
        m = bus.mac;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.mac !== 160'h0) begin failures++; $display("FAIL reset_mac: got %h expected 0", bus.mac); end
        checks++; if (bus.sha_feed !== 1'b0) begin failures++; $display("FAIL reset_feed: got %b expected 0", bus.sha_feed); end
        checks++; if (bus.sha_message !== 512'h0) begin failures++; $display("FAIL reset_msg: got %h expected 0", bus.sha_message); end
        checks++; if (bus.sha_reset !== 1'b1) begin failures++; $display("FAIL reset_sha_reset: got %b expected 1", bus.sha_reset); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.sha_reset !== 1'b0) begin failures++; $display("FAIL idle_sha_reset: got %b expected 0", bus.sha_reset); end
    endtask

    task automatic test_rfc_vectors();
        logic [159:0] m;
        int lat, nbusy, nchg;
        clear_counts();
        run_req(RFC_KEY, 64'd0, m, lat, nbusy, nchg);
        checks++; if (m !== V0) begin failures++; $display("FAIL rfc_c0_mac: got %h expected %h", m, V0); end
        checks++; if (lat != 339) begin failures++; $display("FAIL rfc_c0_latency: got %0d expected 339", lat); end
        checks++; if (nbusy != 338) begin failures++; $display("FAIL rfc_c0_busy_cycles: got %0d expected 338", nbusy); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rfc_c0_busy_at_done: got %b expected 0", bus.busy); end
        checks++; if (n_feed != 4) begin failures++; $display("FAIL rfc_c0_feeds: got %0d expected 4", n_feed); end
        checks++; if (n_sreset != 2) begin failures++; $display("FAIL rfc_c0_sha_resets: got %0d expected 2", n_sreset); end
        checks++; if (n_feed_bad != 0) begin failures++; $display("FAIL rfc_c0_feed_without_done: got %0d expected 0", n_feed_bad); end
        run_req(RFC_KEY, 64'd1, m, lat, nbusy, nchg);
        checks++; if (m !== V1) begin failures++; $display("FAIL rfc_c1_mac: got %h expected %h", m, V1); end
        checks++; if (lat != 339) begin failures++; $display("FAIL rfc_c1_latency: got %0d expected 339", lat); end
        checks++; if (nchg != 0) begin failures++; $display("FAIL rfc_c1_mac_hold: got %0d changed cycles expected 0", nchg); end
        @(posedge clk); #1;
    endtask

    task automatic test_start_while_busy();
        int lat;
        clear_counts();
        bus.key = RFC_KEY; bus.counter = 64'd0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 1000) begin
            bus.start = (lat % 37 == 0);
            if (lat >= 37) begin
                bus.key = '0; bus.counter = 64'd5;
            end
            @(posedge clk); #1;
            lat++;
        end
        bus.start = 1'b0;
        checks++; if (bus.mac !== V0) begin failures++; $display("FAIL busy_start_mac: got %h expected %h", bus.mac, V0); end
        checks++; if (lat != 339) begin failures++; $display("FAIL busy_start_latency: got %0d expected 339", lat); end
        repeat (20) @(posedge clk);
        #1;
        checks++; if (n_done != 1) begin failures++; $display("FAIL busy_start_done_count: got %0d expected 1", n_done); end
        checks++; if (n_feed != 4) begin failures++; $display("FAIL busy_start_feeds: got %0d expected 4", n_feed); end
        checks++; if (n_sreset != 2) begin failures++; $display("FAIL busy_start_sha_resets: got %0d expected 2", n_sreset); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL busy_start_idle_after: got %b expected 0", bus.busy); end
    endtask

    task automatic test_reset_mid_run();
        logic [159:0] m;
        int lat, nbusy, nchg;
        bus.key = RFC_KEY; bus.counter = 64'd3; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (199) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL midrst_done: got %b expected 0", bus.done); end
        checks++; if (bus.mac !== 160'h0) begin failures++; $display("FAIL midrst_mac: got %h expected 0", bus.mac); end
        checks++; if (bus.sha_reset !== 1'b1) begin failures++; $display("FAIL midrst_sha_reset: got %b expected 1", bus.sha_reset); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        clear_counts();
        run_req(RFC_KEY, 64'd0, m, lat, nbusy, nchg);
        checks++; if (m !== V0) begin failures++; $display("FAIL midrst_rerun_mac: got %h expected %h", m, V0); end
        checks++; if (lat != 339) begin failures++; $display("FAIL midrst_rerun_latency: got %0d expected 339", lat); end
        checks++; if (n_feed != 4) begin failures++; $display("FAIL midrst_rerun_feeds: got %0d expected 4", n_feed); end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_key();
        logic [159:0] m, inner, exp_mac;
        logic [511:0] exp_msg [4];
        int lat, nbusy, nchg;
        exp_msg[0] = {64{8'h36}};
        exp_msg[1] = {64'd0, 8'h80, 376'b0, 64'd576};
        inner      = sha1_compress(sha1_compress(SHA_IV, exp_msg[0]), exp_msg[1]);
        exp_msg[2] = {64{8'h5c}};
        exp_msg[3] = {inner, 8'h80, 280'b0, 64'd672};
        exp_mac    = sha1_compress(sha1_compress(SHA_IV, exp_msg[2]), exp_msg[3]);
        clear_counts();
        run_req(512'h0, 64'd0, m, lat, nbusy, nchg);
        checks++; if (m !== exp_mac) begin failures++; $display("FAIL zero_key_mac: got %h expected %h", m, exp_mac); end
        checks++;
        if (msg_q.size() != 4) begin
            failures++; $display("FAIL zero_key_feed_count: got %0d expected 4", msg_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (msg_q[i] !== exp_msg[i]) begin
                    failures++; $display("FAIL zero_key_msg%0d: got %h expected %h", i, msg_q[i], exp_msg[i]);
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [159:0] exp_tab [4];
        logic [159:0] m;
        int lat, nbusy, nchg;
        exp_tab[0] = V0; exp_tab[1] = V1; exp_tab[2] = V2; exp_tab[3] = V3;
        clear_counts();
        for (int i = 0; i < 4; i++) begin
            run_req(RFC_KEY, 64'(i), m, lat, nbusy, nchg);
            checks++; if (m !== exp_tab[i]) begin failures++; $display("FAIL b2b_mac%0d: got %h expected %h", i, m, exp_tab[i]); end
            checks++; if (lat != 339) begin failures++; $display("FAIL b2b_spacing%0d: got %0d expected 339", i, lat); end
        end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (n_done != 4) begin failures++; $display("FAIL b2b_done_count: got %0d expected 4", n_done); end
        checks++; if (n_feed != 16) begin failures++; $display("FAIL b2b_feeds: got %0d expected 16", n_feed); end
        checks++; if (n_feed_bad != 0) begin failures++; $display("FAIL b2b_feed_without_done: got %0d expected 0", n_feed_bad); end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.key = '0;
        bus.counter = '0;
        test_reset();
        test_rfc_vectors();
        test_start_while_busy();
        test_reset_mid_run();
        test_zero_key();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
